// File: rtl/i2c_target.sv
// I2C target with 7-bit address and an auto-incrementing 8-bit register pointer.
// Bus pins are synchronized on clk; sda_o is the open-drain enable (0 = pull low).
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_scl_meta, r_scl_s, r_scl_d;
  logic            r_sda_meta, r_sda_s, r_sda_d;
  logic            r_sda_o, r_busy, r_rw, r_ack_phase;
  logic            r_reg_we, r_reg_re;
  logic [DW-1:0]   r_reg_addr, r_reg_wdata;
  logic [CW-1:0]   r_bit_cnt;
  logic [DW-2:0]   r_shift;
  logic [DW-2:0]   r_tx;
  logic            w_scl_rise, w_scl_fall, w_start, w_stop;
  logic            w_last, w_ack_end, w_match;
  logic [DW-1:0]   w_byte;

  // Two-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_meta <= 1'b1; r_scl_s <= 1'b1; r_scl_d <= 1'b1;
      r_sda_meta <= 1'b1; r_sda_s <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_meta <= scl_i; r_scl_s <= r_scl_meta; r_scl_d <= r_scl_s;
      r_sda_meta <= sda_i; r_sda_s <= r_sda_meta; r_sda_d <= r_sda_s;
    end
  end

  assign w_scl_rise = r_scl_s & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s & r_scl_d;
  assign w_start    = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
  assign w_stop     = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
  assign w_byte     = {r_shift, r_sda_s};
  assign w_last     = w_scl_rise && (r_bit_cnt == 3'd7);
  assign w_ack_end  = w_scl_fall && r_ack_phase;
  assign w_match    = (w_byte[7:1] == TARGET_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:     if (w_last) w_state_nxt = w_match ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: if (w_ack_end) w_state_nxt = r_rw ? ST_RD : ST_PTR;
        ST_PTR:      if (w_last) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK,
        ST_WR_ACK:   if (w_ack_end) w_state_nxt = ST_WR;
        ST_WR:       if (w_last) w_state_nxt = ST_WR_ACK;
        ST_RD:       if (w_scl_fall && (r_bit_cnt == 3'd7)) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK: begin
          if (w_scl_rise && !r_ack_phase && r_sda_s) w_state_nxt = ST_IDLE;
          else if (w_ack_end)                        w_state_nxt = ST_RD;
        end
        default: ;
      endcase
    end
  end

  // Datapath: shifting, ACK drive, strobes and pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sda_o     <= 1'b1;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
    end else begin
      r_reg_we <= 1'b0;
      r_reg_re <= 1'b0;
      if (r_reg_we || r_reg_re) r_reg_addr <= r_reg_addr + 8'd1;
      if (r_reg_re) begin
        r_tx    <= reg_rdata[6:0];
        r_sda_o <= reg_rdata[7];
      end
      if (w_start || w_stop) begin
        r_sda_o     <= 1'b1;
        r_busy      <= 1'b0;
        r_bit_cnt   <= '0;
        r_ack_phase <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WR: if (w_scl_rise) begin
            r_shift     <= w_byte[6:0];
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_ack_phase <= 1'b0;
            if (w_last) begin
              if (r_state == ST_ADDR && w_match) begin
                r_rw   <= w_byte[0];
                r_busy <= 1'b1;
              end
              if (r_state == ST_PTR) r_reg_addr <= w_byte;
              if (r_state == ST_WR) begin
                r_reg_we    <= 1'b1;
                r_reg_wdata <= w_byte;
              end
            end
          end
          // First fall pulls SDA low, second fall releases it
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (w_scl_fall) begin
            r_ack_phase <= ~r_ack_phase;
            r_sda_o     <= r_ack_phase;
            r_bit_cnt   <= '0;
            if (r_ack_phase && r_state == ST_ADDR_ACK && r_rw) r_reg_re <= 1'b1;
          end
          ST_RD: if (w_scl_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_sda_o   <= (r_bit_cnt == 3'd7) ? 1'b1 : r_tx[6];
            r_tx      <= {r_tx[5:0], 1'b0};
          end
          ST_RD_ACK: begin
            if (w_scl_rise && !r_ack_phase) begin
              if (r_sda_s) r_busy      <= 1'b0;
              else         r_ack_phase <= 1'b1;
            end
            if (w_ack_end) begin
              r_ack_phase <= 1'b0;
              r_reg_re    <= 1'b1;
              r_bit_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_o     = r_sda_o;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_we    = r_reg_we;
  assign reg_re    = r_reg_re;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, register bank, and a
// byte-level reference model (pointer + memory image) built from the bus rules.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_scl, m_sda;
  logic       sda_o;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;
  logic       w_line;

  logic [7:0] bank  [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  logic [15:0] obs_wr[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  wq[$];
  int          n_re, exp_re;
  bit          sda_low_seen;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign w_line    = m_sda & sda_o;
  assign reg_rdata = bank[reg_addr];

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(w_line),
    .sda_o(sda_o), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register bank and strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
      obs_wr.push_back({reg_addr, reg_wdata});
    end
    if (reg_re) n_re++;
    if (!sda_o) sda_low_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic t_bit(input logic b, output logic s);
    clks(8);  m_sda = b;
    clks(12); m_scl = 1'b1;
    clks(10); s = w_line;
    clks(10); m_scl = 1'b0;
  endtask

  task automatic t_start();
    clks(8);  m_sda = 1'b1;
    clks(12); m_scl = 1'b1;
    clks(10); m_sda = 1'b0;
    clks(10); m_scl = 1'b0;
  endtask

  task automatic t_stop();
    clks(8);  m_sda = 1'b0;
    clks(12); m_scl = 1'b1;
    clks(10); m_sda = 1'b1;
    clks(20);
  endtask

  task automatic t_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) t_bit(b[i], s);
    t_bit(1'b1, ack);
  endtask

  task automatic t_rbyte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      t_bit(1'b1, s);
      d[i] = s;
    end
    t_bit(mack, s);
  endtask

  task automatic clear_obs();
    obs_wr.delete(); exp_wr.delete();
    n_re = 0; exp_re = 0; sda_low_seen = 1'b0;
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_we_cnt"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      chk({tag, "_we_addr_data"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    chk({tag, "_re_cnt"}, 32'(n_re), 32'(exp_re));
    chk({tag, "_ptr"}, 32'(reg_addr), 32'(m_ptr));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_sda_rel"}, 32'(sda_o), 32'd1);
    clear_obs();
  endtask

  task automatic do_write(input logic [7:0] ptr);
    logic a;
    t_start();
    t_wbyte(8'hA0, a);
    chk("w_addr_ack", 32'(a), 32'd0);
    chk("w_busy", 32'(busy), 32'd1);
    t_wbyte(ptr, a);
    chk("w_ptr_ack", 32'(a), 32'd0);
    m_ptr = ptr;
    foreach (wq[i]) begin
      t_wbyte(wq[i], a);
      chk("w_data_ack", 32'(a), 32'd0);
      exp_wr.push_back({m_ptr, wq[i]});
      m_mem[m_ptr] = wq[i];
      m_ptr = m_ptr + 8'd1;
    end
    t_stop();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    if (set_ptr) begin
      t_start();
      t_wbyte(8'hA0, a);
      chk("r_waddr_ack", 32'(a), 32'd0);
      t_wbyte(ptr, a);
      chk("r_ptr_ack", 32'(a), 32'd0);
      m_ptr = ptr;
    end
    t_start();
    t_wbyte(8'hA1, a);
    chk("r_addr_ack", 32'(a), 32'd0);
    for (int i = 0; i < n; i++) begin
      t_rbyte((i == n - 1), d);
      chk("r_data", 32'(d), 32'(m_mem[m_ptr]));
      m_ptr = m_ptr + 8'd1;
      exp_re++;
    end
    chk("r_nack_release", 32'(sda_o), 32'd1);
    t_stop();
  endtask

  task automatic do_wrong_addr(input logic [7:0] b);
    logic a;
    sda_low_seen = 1'b0;
    t_start();
    t_wbyte(b, a);
    chk("x_nack", 32'(a), 32'd1);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_sda_never_low", 32'(sda_low_seen), 32'd0);
    t_stop();
  endtask

  initial begin
    logic a, s;
    for (int i = 0; i < 256; i++) begin
      bank[i]  = ~8'(i);
      m_mem[i] = ~8'(i);
    end
    m_scl = 1'b1; m_sda = 1'b1; reset_n = 1'b0;
    clear_obs();
    m_ptr = 8'h00;
    clks(5);
    chk("rst_sda", 32'(sda_o), 32'd1);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_re", 32'(reg_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    clks(10);

    do_wrong_addr(8'hA2);
    check_end("mismatch");

    wq = '{8'h5A, 8'hC3};
    do_write(8'h10);
    check_end("multi_wr");

    do_read(1'b1, 8'h20, 2);
    check_end("ptr_then_rd");

    wq = '{8'($urandom), 8'($urandom)};
    do_write(8'hFF);
    check_end("wrap");

    // STOP after four data bits: no write strobe
    t_start();
    t_wbyte(8'hA0, a);
    t_wbyte(8'h30, a);
    m_ptr = 8'h30;
    t_bit(1'b1, s); t_bit(1'b0, s); t_bit(1'b1, s); t_bit(1'b1, s);
    t_stop();
    check_end("stop_mid");

    // Reset while the address ACK is on the bus
    t_start();
    for (int i = 7; i >= 0; i--) t_bit(((8'hA0 >> i) & 8'h01) != 8'h00, s);
    clks(8);  m_sda = 1'b1;
    clks(12); m_scl = 1'b1;
    clks(10);
    chk("ack_before_rst", 32'(sda_o), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_async_sda", 32'(sda_o), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    clks(3);
    reset_n = 1'b1;
    clks(10);
    m_ptr = 8'h00;
    clear_obs();
    chk("rst_ptr_zero", 32'(reg_addr), 32'd0);
    wq = '{8'($urandom)};
    do_write(8'h40);
    check_end("after_rst");

    for (int t = 0; t < 12; t++) begin
      int kind, n;
      logic [6:0] ad;
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      if (kind == 0) begin
        wq.delete();
        repeat (n) wq.push_back(8'($urandom));
        do_write(8'($urandom));
      end else if (kind == 1) begin
        do_read(1'($urandom), 8'($urandom), n);
      end else begin
        ad = 7'($urandom);
        if (ad == 7'h50) ad = 7'h51;
        do_wrong_addr({ad, 1'($urandom)});
      end
      check_end("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
